// File: rtl/mat_mul_seq_if.sv
// Element-stream interface of the layer sequencer: load stream in, result stream out.
// The master drives loads and consumes results; the slave is the sequencer.
interface mat_mul_seq_if #(
    parameter int W = 16
) ();
    logic                ld_valid;
    logic                ld_ready;
    logic signed [W-1:0] ld_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;

    modport master (
        output ld_valid, ld_data, out_ready,
        input  ld_ready, out_valid, out_data
    );

    modport slave (
        input  ld_valid, ld_data, out_ready,
        output ld_ready, out_valid, out_data
    );
endinterface

// File: rtl/mat_mul_seq.sv
// Multi-layer y = W*x + b sequencer around one shared combinational mat_mul,
// loading operands and draining results one element at a time.

module mat_mul #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic signed [W-1:0] x [N],
    input  logic signed [W-1:0] w [N*N],
    input  logic signed [W-1:0] b [N],
    output logic signed [W-1:0] y [N]
);
    localparam int AW = 2*W + $clog2(N) + 1;

    // Full-precision sum; only the low W bits leave, giving two's-complement wrap.
    always_comb begin
        logic signed [AW-1:0] acc;
        for (int i = 0; i < N; i++) begin
            acc = AW'(b[i]);
            for (int j = 0; j < N; j++) begin
                acc = acc + AW'(x[j]) * AW'(w[i*N + j]);
            end
            y[i] = acc[W-1:0];
        end
    end
endmodule

// state   | meaning
// IDLE    | waiting for start
// LD_X    | loading input vector x (N elements)
// LD_W    | loading weight matrix row-major (N*N elements)
// LD_B    | loading bias vector (N elements)
// COMPUTE | one cycle: x <= mat_mul result (optional ReLU on non-final layers)
// OUT     | streaming x out (N elements)
module mat_mul_seq #(
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int L_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(L_MAX+1)-1:0]   num_layers,
    input  logic                         relu_en,
    mat_mul_seq_if.slave                 bus,
    output logic                         busy,
    output logic                         done
);
    localparam int NW = $clog2(N);
    localparam int CW = $clog2(N*N);
    localparam int LW = $clog2(L_MAX+1);
    localparam logic [CW-1:0] LAST_N  = CW'(N-1);
    localparam logic [CW-1:0] LAST_NN = CW'(N*N-1);

    typedef enum logic [2:0] {IDLE, LD_X, LD_W, LD_B, COMPUTE, OUT} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [LW-1:0]       layer_cnt, layers_tgt, layers_eff;
    logic                relu_r;
    logic signed [W-1:0] x [N];
    logic signed [W-1:0] w [N*N];
    logic signed [W-1:0] b [N];
    logic signed [W-1:0] y [N];
    logic                loading, ld_fire, out_fire, cnt_last, last_layer;

    mat_mul #(.N(N), .W(W)) u_mat_mul (
        .x (x),
        .w (w),
        .b (b),
        .y (y)
    );

    assign loading    = (state == LD_X) || (state == LD_W) || (state == LD_B);
    assign ld_fire    = loading && bus.ld_valid;
    assign out_fire   = (state == OUT) && bus.out_ready;
    assign cnt_last   = (state == LD_W) ? (cnt == LAST_NN) : (cnt == LAST_N);
    assign last_layer = (layer_cnt == layers_tgt - 1'b1);

    always_comb begin
        layers_eff = num_layers;
        if (num_layers == '0) begin
            layers_eff = LW'(1);
        end else if (num_layers > LW'(L_MAX)) begin
            layers_eff = LW'(L_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)               state_nxt = LD_X;
            LD_X:    if (ld_fire && cnt_last) state_nxt = LD_W;
            LD_W:    if (ld_fire && cnt_last) state_nxt = LD_B;
            LD_B:    if (ld_fire && cnt_last) state_nxt = COMPUTE;
            COMPUTE: state_nxt = last_layer ? OUT : LD_W;
            OUT:     if (out_fire && cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ld_ready  = loading;
        bus.out_valid = (state == OUT);
        bus.out_data  = (state == OUT) ? x[cnt[NW-1:0]] : '0;
        busy          = (state != IDLE);
        done          = out_fire && cnt_last;
    end

    // Element counter returns to 0 on its last element, so every phase starts at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            layer_cnt  <= '0;
            layers_tgt <= '0;
            relu_r     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x[i] <= '0;
                b[i] <= '0;
            end
            for (int i = 0; i < N*N; i++) begin
                w[i] <= '0;
            end
        end else begin
            if (ld_fire || out_fire) begin
                cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        layers_tgt <= layers_eff;
                        relu_r     <= relu_en;
                        layer_cnt  <= '0;
                    end
                end
                LD_X: if (ld_fire) x[cnt[NW-1:0]] <= bus.ld_data;
                LD_W: if (ld_fire) w[cnt]         <= bus.ld_data;
                LD_B: if (ld_fire) b[cnt[NW-1:0]] <= bus.ld_data;
                COMPUTE: begin
                    for (int i = 0; i < N; i++) begin
                        x[i] <= (relu_r && !last_layer && y[i][W-1]) ? '0 : y[i];
                    end
                    layer_cnt <= layer_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed bench for mat_mul_seq at N=4, W=16: hand-computed layer results,
// backpressure, mid-load reset, wrap-around and ignored start.
module tb_mat_mul_seq;
    localparam int N     = 4;
    localparam int W     = 16;
    localparam int L_MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] num_layers;
    logic       relu_en;
    logic       busy;
    logic       done;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int gap       = 0;
    int stall_out = 0;

    mat_mul_seq_if #(.W(W)) bus ();

    mat_mul_seq #(.N(N), .W(W), .L_MAX(L_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_layers (num_layers),
        .relu_en    (relu_en),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        int n = 0;
        bus.ld_data  = 16'(v);
        bus.ld_valid = 1'b1;
        while (bus.ld_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("ld_ready_timeout", bus.ld_ready, 1);
        step();
        bus.ld_valid = 1'b0;
        if (gap != 0) step();
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        push(a); push(b); push(c); push(d);
    endtask

    task automatic push_fill(input int n, input int v);
        for (int i = 0; i < n; i++) push(v);
    endtask

    task automatic push_ident();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) push((r == c) ? 1 : 0);
    endtask

    task automatic start_run(input int nl, input logic relu);
        start      = 1'b1;
        num_layers = 3'(nl);
        relu_en    = relu;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check({tag, "_valid_timeout"}, bus.out_valid, 1);
    endtask

    task automatic expect4(input string tag, input int a, input int b, input int c, input int d);
        int e[4];
        int dc0;
        e   = '{a, b, c, d};
        dc0 = done_cnt;
        for (int k = 0; k < N; k++) begin
            wait_valid(tag);
            if (stall_out != 0) begin
                bus.out_ready = 1'b0;
                step();
                check($sformatf("%s_stall_valid%0d", tag, k), bus.out_valid, 1);
                check($sformatf("%s_stall_data%0d", tag, k), bus.out_data, e[k]);
            end
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("%s_data%0d", tag, k), bus.out_data, e[k]);
            check($sformatf("%s_done%0d", tag, k), done, (k == N-1) ? 1 : 0);
            step();
            bus.out_ready = 1'b0;
        end
        check({tag, "_done_pulses"}, done_cnt - dc0, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_valid_end"}, bus.out_valid, 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_layers   = 3'd1;
        relu_en      = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.out_ready = 1'b0;
        step(); step();
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_data", bus.out_data, 0);
        rst = 1'b0;
        step();

        // all zeros, one layer
        start_run(1, 1'b0);
        push_fill(N, 0); push_fill(N*N, 0); push_fill(N, 0);
        expect4("zeros", 0, 0, 0, 0);

        // identity, final layer so no ReLU
        start_run(1, 1'b1);
        push4(1, -2, 3, -4); push_ident(); push_fill(N, 10);
        expect4("ident", 11, 8, 13, 6);

        // two layers with ReLU
        start_run(2, 1'b1);
        push4(5, -3, 2, -7); push_ident(); push_fill(N, 0);
        push_fill(N*N, 1); push4(1, 2, 3, 4);
        expect4("two_relu", 8, 9, 10, 11);

        // two layers without ReLU
        start_run(2, 1'b0);
        push4(5, -3, 2, -7); push_ident(); push_fill(N, 0);
        push_fill(N*N, 1); push4(1, 2, 3, 4);
        expect4("two_norelu", -2, -1, 0, 1);

        // backpressure on both streams
        gap = 1;
        stall_out = 1;
        start_run(2, 1'b1);
        push4(5, -3, 2, -7); push_ident(); push_fill(N, 0);
        push_fill(N*N, 1); push4(1, 2, 3, 4);
        expect4("bp", 8, 9, 10, 11);
        gap = 0;
        stall_out = 0;

        // reset in the middle of the weight load
        start_run(1, 1'b1);
        push4(1, -2, 3, -4); push_fill(7, 1);
        rst = 1'b1;
        #1;
        check("midrst_ld_ready", bus.ld_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        step();
        rst = 1'b0;
        step();
        start_run(1, 1'b1);
        push4(1, -2, 3, -4); push_ident(); push_fill(N, 10);
        expect4("after_rst", 11, 8, 13, 6);

        // wrap: row0 sums to 65536 -> 0, row1 to 32768 -> -32768; start during OUT ignored
        start_run(1, 1'b0);
        push_fill(N, 1);
        push_fill(N, 16384);
        push4(16384, 16384, 0, 0);
        push_fill(2*N, 0);
        push_fill(N, 0);
        wait_valid("wrap");
        check("out_ld_ready", bus.ld_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_out_valid", bus.out_valid, 1);
        check("start_in_out_data", bus.out_data, 0);
        expect4("wrap", 0, -32768, 0, 0);

        // num_layers=0 runs a single layer
        start_run(0, 1'b1);
        push4(1, -2, 3, -4); push_ident(); push_fill(N, 10);
        expect4("nl0", 11, 8, 13, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
